// File: rtl/if_stage_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Latency: n/a (types only).
// Backpressure: n/a.
package if_stage_pkg;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    // Decode-stage input bundle; fetch output is the same layout.
    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] pc4;
    } id_stage_in_t;

    typedef id_stage_in_t if_stage_out_t;

    typedef struct packed {
        logic        req;
        logic [31:0] addr;
    } if_imem_req_t;

    localparam if_stage_out_t NOP_BUBBLE = '{inst: NOP_INST, pc: 32'h0, pc4: 32'h0};

endpackage

// File: rtl/fetch_fifo.sv
// Small FIFO for fetched instructions and for in-flight fetch address tags.
// Latency: a pushed entry is visible at head the cycle after the push.
// Backpressure: none internal; caller never pushes when full or pops when empty; clear wins.
module fetch_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 96,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             clear,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    localparam logic [CW-1:0] DEPTH_W = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    // Storage needs no reset; only pointers and count define validity.
    always_ff @(posedge clk) begin
        if (push && !clear) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy tracking; depth is a power of two so pointers wrap naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

    assign head  = mem[rd_ptr];
    assign empty = (count == '0);
    assign full  = (count == DEPTH_W);

endmodule

// File: rtl/if_stage.sv
// Instruction fetch: owns the PC, issues in-order imem requests, buffers replies for decode.
// Latency: rvalid to if_valid_o is 1 cycle when the buffer is empty and decode is not stalled.
// Backpressure: stall_i holds the output; requests stop once in-flight + buffered reaches FIFO_DEPTH.
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic [95:0] if_out_o,
    output logic        if_valid_o
);

    localparam int              CW      = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW:0]     DEPTH_W = (CW+1)'(FIFO_DEPTH);

    fetch_state_t  state;
    logic [31:0]   pc;
    if_imem_req_t  imem_req;
    if_stage_out_t out_q;
    logic          out_vld;
    if_stage_out_t resp_entry;
    if_stage_out_t fifo_head;
    logic [31:0]   aq_head;
    logic [CW-1:0] aq_count;
    logic [CW-1:0] fifo_count;
    logic [CW-1:0] outstanding_next;
    logic [CW:0]   credit_used;
    logic          aq_full, aq_empty, fifo_full, fifo_empty;
    logic          fire, resp_ok, fifo_push, fifo_pop;

    // The address queue occupancy doubles as the outstanding-request counter.
    assign credit_used      = {1'b0, aq_count} + {1'b0, fifo_count};
    assign fire             = imem_req.req & imem_gnt_i;
    assign outstanding_next = aq_count + CW'(fire) - CW'(imem_rvalid_i);

    // Request only in FETCH and only while a buffer slot is guaranteed for the reply.
    always_comb begin
        imem_req.req  = 1'b0;
        imem_req.addr = pc;
        if (state == FETCH && credit_used < DEPTH_W) begin
            imem_req.req = 1'b1;
        end
    end

    assign imem_req_o  = imem_req.req;
    assign imem_addr_o = imem_req.addr;

    // Replies are only useful in FETCH; a redirect in the same cycle makes them stale.
    assign resp_ok    = imem_rvalid_i && (state == FETCH) && !redirect_i;
    assign resp_entry = '{inst: imem_rdata_i, pc: aq_head, pc4: aq_head + 32'd4};
    // Bypass straight into the output register when nothing is queued ahead.
    assign fifo_push  = resp_ok && (stall_i || !fifo_empty);
    assign fifo_pop   = !redirect_i && !stall_i && !fifo_empty;

    fetch_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(32)) u_addr_q (
        .clk       (clk),
        .rst       (rst),
        .push      (fire),
        .push_data (pc),
        .pop       (imem_rvalid_i && !aq_empty),
        .clear     (1'b0),
        .head      (aq_head),
        .full      (aq_full),
        .empty     (aq_empty),
        .count     (aq_count)
    );

    fetch_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(96)) u_inst_q (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (resp_entry),
        .pop       (fifo_pop),
        .clear     (redirect_i),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Fetch FSM and PC: redirect overrides everything; stale replies are drained before refetch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= BOOT;
            pc    <= RESET_PC;
        end else if (redirect_i) begin
            pc    <= {redirect_pc_i[31:2], 2'b00};
            state <= (outstanding_next != '0) ? DRAIN : FETCH;
        end else begin
            if (fire) pc <= pc + 32'd4;
            case (state)
                BOOT:    state <= FETCH;
                FETCH:   state <= FETCH;
                DRAIN:   if (outstanding_next == '0) state <= FETCH;
                default: state <= BOOT;
            endcase
        end
    end

    // Output register toward decode: bubble on redirect, hold on stall, else next instruction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q   <= NOP_BUBBLE;
            out_vld <= 1'b0;
        end else if (redirect_i) begin
            out_q   <= NOP_BUBBLE;
            out_vld <= 1'b0;
        end else if (!stall_i) begin
            if (!fifo_empty) begin
                out_q   <= fifo_head;
                out_vld <= 1'b1;
            end else if (resp_ok) begin
                out_q   <= resp_entry;
                out_vld <= 1'b1;
            end else begin
                out_q   <= NOP_BUBBLE;
                out_vld <= 1'b0;
            end
        end
    end

    assign if_out_o   = out_q;
    assign if_valid_o = out_vld;

    // The credit rule makes overflow unreachable; a reply with nothing in flight is a memory bug.
    a_no_fifo_overflow : assert property (@(posedge clk) disable iff (rst) !(fifo_push && fifo_full && !fifo_pop));
    a_no_aq_overflow   : assert property (@(posedge clk) disable iff (rst) !(fire && aq_full));
    a_no_orphan_rvalid : assert property (@(posedge clk) disable iff (rst) !(imem_rvalid_i && aq_empty));

endmodule

// File: tb/tb_if_stage.sv
module tb_if_stage;

    localparam int          DEPTH  = 2;
    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [95:0] BUBBLE = {32'h0000_0013, 64'h0};

    logic        clk;
    logic        rst         = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt    = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata  = 32'h0;
    logic        stall       = 1'b0;
    logic        redirect    = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic [95:0] if_out;
    logic        if_valid;

    if_stage #(.RESET_PC(RST_PC), .FIFO_DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst           (rst),
        .imem_req_o    (imem_req),
        .imem_addr_o   (imem_addr),
        .imem_gnt_i    (imem_gnt),
        .imem_rvalid_i (imem_rvalid),
        .imem_rdata_i  (imem_rdata),
        .stall_i       (stall),
        .redirect_i    (redirect),
        .redirect_pc_i (redirect_pc),
        .if_out_o      (if_out),
        .if_valid_o    (if_valid)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_errors = 0;
    int consumed = 0;
    logic [31:0] exp_q[$];

    // memory model state
    typedef struct {
        logic [31:0] addr;
        int          ready;
    } pend_t;
    pend_t mq[$];
    int cyc      = 0;
    int gnt_wait = 0;
    int gnt_max  = 0;
    int rsp_min  = 0;
    int rsp_max  = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hC0DE_0003;
    endfunction

    function automatic logic [95:0] exp_entry(input logic [31:0] p);
        return {mem_word(p), p, p + 32'd4};
    endfunction

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push_seq(input logic [31:0] base, input int n);
        exp_q.delete();
        for (int i = 0; i < n; i++) exp_q.push_back(base + 32'(4 * i));
    endtask

    // Memory: in-order replies, random grant wait and reply latency, reset from the same rst.
    initial begin
        pend_t p;
        int    cnt;
        forever begin
            @(negedge clk);
            cyc++;
            imem_gnt    = 1'b0;
            imem_rvalid = 1'b0;
            if (rst) begin
                mq.delete();
                gnt_wait = 0;
            end else begin
                if (mq.size() != 0 && mq[0].ready <= cyc) begin
                    p           = mq.pop_front();
                    imem_rvalid = 1'b1;
                    imem_rdata  = mem_word(p.addr);
                end
                if (imem_req) begin
                    if (gnt_wait == 0) begin
                        imem_gnt = 1'b1;
                        p.addr   = imem_addr;
                        p.ready  = cyc + 1 + int'($urandom_range(rsp_min, rsp_max));
                        mq.push_back(p);
                        gnt_wait = int'($urandom_range(0, gnt_max));
                        cnt = mq.size() + (imem_rvalid ? 1 : 0);
                        n_checks++;
                        assert (cnt <= DEPTH) else begin
                            n_errors++;
                            $error("FAIL outstanding_cap: observed=%0d limit=%0d", cnt, DEPTH);
                        end
                    end else begin
                        gnt_wait--;
                    end
                end
            end
        end
    end

    // Scoreboard: every instruction decode accepts must be the next expected pc.
    initial begin
        logic [31:0] p;
        logic        have;
        forever begin
            @(negedge clk);
            #4;
            if (!rst && if_valid && !stall && !redirect) begin
                have = (exp_q.size() != 0);
                chk("sb_pending", 96'(have), 96'd1);
                if (have) begin
                    p = exp_q.pop_front();
                    chk("sb_inst", if_out, exp_entry(p));
                end
                consumed++;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Directed sequence
    initial begin
        logic        found;
        logic [31:0] raw;
        int          base;

        // reset values
        repeat (3) @(negedge clk);
        #4;
        chk("rst_valid", 96'(if_valid), 96'd0);
        chk("rst_out", if_out, BUBBLE);
        chk("rst_req", 96'(imem_req), 96'd0);
        chk("rst_addr", 96'(imem_addr), 96'(RST_PC));

        // reset release, 1-cycle memory
        @(negedge clk);
        push_seq(RST_PC, 64);
        rst = 1'b0;
        #4;
        chk("boot_req", 96'(imem_req), 96'd0);
        @(negedge clk); #4;
        chk("first_req", 96'(imem_req), 96'd1);
        chk("first_addr", 96'(imem_addr), 96'h0);
        @(negedge clk);
        @(negedge clk); #4;
        chk("first_valid", 96'(if_valid), 96'd1);
        chk("first_out", if_out, exp_entry(32'h0));
        @(negedge clk); #4;
        chk("second_out", if_out, exp_entry(32'h4));
        @(negedge clk); #4;
        chk("third_out", if_out, exp_entry(32'h8));

        // stall for 3 cycles
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            stall = 1'b1;
            #4;
            chk("stall_hold", if_out, exp_entry(exp_q[0]));
            chk("stall_valid", 96'(if_valid), 96'd1);
            if (i == 2) chk("stall_req_off", 96'(imem_req), 96'd0);
        end
        @(negedge clk);
        stall = 1'b0;

        // redirect with two requests in flight
        rsp_min = 3;
        rsp_max = 3;
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            @(negedge clk);
            #2;
            if (mq.size() == 2 && !imem_rvalid) found = 1'b1;
        end
        chk("wait_two_inflight", 96'(found), 96'd1);
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0103;
        push_seq(32'h0000_0100, 40);
        @(negedge clk);
        redirect = 1'b0;
        #4;
        chk("redir_valid", 96'(if_valid), 96'd0);
        chk("redir_out", if_out, BUBBLE);
        chk("drain_req", 96'(imem_req), 96'd0);
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            if (imem_req) found = 1'b1;
            else begin @(negedge clk); #4; end
        end
        chk("refetch_seen", 96'(found), 96'd1);
        chk("refetch_addr", 96'(imem_addr), 96'h100);
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            if (if_valid) found = 1'b1;
            else begin @(negedge clk); #4; end
        end
        chk("redir_first_valid", 96'(found), 96'd1);
        chk("redir_first_out", if_out, exp_entry(32'h100));

        // redirect coincident with stall
        repeat (4) @(negedge clk);
        stall       = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0200;
        push_seq(32'h0000_0200, 40);
        @(negedge clk);
        stall    = 1'b0;
        redirect = 1'b0;
        #4;
        chk("redir_stall_valid", 96'(if_valid), 96'd0);
        chk("redir_stall_out", if_out, BUBBLE);

        // random memory timing and random stalls, 4 x 250 instructions
        gnt_max = 5;
        rsp_min = 0;
        rsp_max = 5;
        for (int seg = 0; seg < 4; seg++) begin
            @(negedge clk);
            raw = (seg == 0) ? 32'hFFFF_FF02 : $urandom;
            redirect    = 1'b1;
            redirect_pc = raw;
            stall       = ($urandom_range(0, 4) == 0);
            push_seq({raw[31:2], 2'b00}, 300);
            @(negedge clk);
            redirect = 1'b0;
            base  = consumed;
            found = 1'b0;
            for (int i = 0; i < 5000 && !found; i++) begin
                stall = ($urandom_range(0, 4) == 0);
                @(negedge clk);
                if (consumed - base >= 250) found = 1'b1;
            end
            chk("seg_progress", 96'(found), 96'd1);
        end
        stall = 1'b0;

        // reset asserted while draining
        gnt_max = 0;
        rsp_min = 3;
        rsp_max = 3;
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            @(negedge clk);
            #2;
            if (mq.size() == 2 && !imem_rvalid) found = 1'b1;
        end
        chk("wait_two_inflight2", 96'(found), 96'd1);
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0300;
        push_seq(32'h0000_0300, 10);
        @(negedge clk);
        redirect = 1'b0;
        #2;
        rst = 1'b1;
        push_seq(RST_PC, 30);
        #1;
        chk("arst_valid", 96'(if_valid), 96'd0);
        chk("arst_out", if_out, BUBBLE);
        chk("arst_req", 96'(imem_req), 96'd0);
        chk("arst_addr", 96'(imem_addr), 96'(RST_PC));
        repeat (2) @(negedge clk);
        rst = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            @(negedge clk); #4;
            if (if_valid) found = 1'b1;
        end
        chk("restart_valid", 96'(found), 96'd1);
        chk("restart_out", if_out, exp_entry(RST_PC));
        repeat (20) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
